// File: rtl/digi_readout_sched.sv
// Readout scheduler for NCH digitizer slices.
// On a trigger it walks the enabled channels in ascending order, reads
// `howmany` words from each one and emits a framed stream:
// header, samples, ..., trailer. The output goes through a 2-entry FIFO
// that uses a valid/ready handshake.
module digi_readout_sched #(
    parameter int NCH     = 4,
    parameter int WIDTH   = 16,
    parameter int SIZE    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                 CK50,
    input  logic                 RST_n,
    input  logic                 TRIGGER,
    input  logic [NCH-1:0]       ch_mask,
    input  logic [SIZE-1:0]      howmany,
    input  logic [NCH-1:0]       ch_rodone_n,
    input  logic [NCH*WIDTH-1:0] ch_dout,
    output logic [NCH-1:0]       ch_rd_request,
    output logic [WIDTH-1:0]     ro_data,
    output logic                 ro_valid,
    input  logic                 ro_ready,
    output logic                 ro_last,
    output logic                 busy,
    output logic                 trig_lost,
    output logic                 timeout_err
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, HDR, READ, WAITDN, NEXT, TRL} state_t;

    state_t            state_q, state_d;
    logic [CHW-1:0]    ch_q;
    logic [NCH-1:0]    mask_q;
    logic [SIZE-1:0]   hm_q;
    logic [SIZE:0]     req_cnt, rcv_cnt;
    logic [TW-1:0]     tmr;
    logic              trl_sent;
    logic              inflight;

    // output FIFO: two entries of {last, data}
    logic [1:0][WIDTH:0] mem;
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_cnt;

    logic              pop, push, fifo_room;
    logic [WIDTH:0]    push_word;
    logic              accept, hdr_push, trl_push, rd_req_en, tmo;
    logic [CHW-1:0]    first_ch, nxt_ch;
    logic              nxt_found;
    logic [WIDTH-1:0]  sample;

    assign ro_valid  = (fifo_cnt != 2'd0);
    assign ro_data   = mem[rd_ptr][WIDTH-1:0];
    assign ro_last   = ro_valid & mem[rd_ptr][WIDTH];
    assign pop       = ro_valid & ro_ready;
    assign fifo_room = (fifo_cnt != 2'd2) | pop;
    assign busy      = (state_q != IDLE);
    assign sample    = ch_dout[int'(ch_q)*WIDTH +: WIDTH];

    // Lowest enabled channel at trigger time, and the next enabled channel above ch_q
    always_comb begin
        first_ch  = '0;
        nxt_ch    = '0;
        nxt_found = 1'b0;
        for (int i = NCH-1; i >= 0; i--) begin
            if (ch_mask[i])
                first_ch = CHW'(i);
            if (mask_q[i] && (i > int'(ch_q))) begin
                nxt_ch    = CHW'(i);
                nxt_found = 1'b1;
            end
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        hdr_push  = 1'b0;
        trl_push  = 1'b0;
        rd_req_en = 1'b0;
        tmo       = 1'b0;
        case (state_q)
            IDLE: begin
                if (TRIGGER && (|ch_mask)) begin
                    accept  = 1'b1;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (fifo_room) begin
                    hdr_push = 1'b1;
                    state_d  = (hm_q == '0) ? NEXT : READ;
                end
            end
            READ: begin
                if (rcv_cnt == {1'b0, hm_q})
                    state_d = WAITDN;
                // a strobe is issued only if the word it returns is sure to have a FIFO slot
                else if ((req_cnt < {1'b0, hm_q}) &&
                         (({1'b0, fifo_cnt} + {2'b00, inflight}) < 3'd2))
                    rd_req_en = 1'b1;
            end
            WAITDN: begin
                if (!ch_rodone_n[ch_q])
                    state_d = NEXT;
                else if (tmr == TW'(TIMEOUT - 1)) begin
                    tmo     = 1'b1;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                state_d = nxt_found ? HDR : TRL;
            end
            TRL: begin
                if (!trl_sent && fifo_room)
                    trl_push = 1'b1;
                // leave only once the trailer has actually left the FIFO
                if (pop && mem[rd_ptr][WIDTH])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ch_rd_request = rd_req_en ? (NCH'(1) << ch_q) : '0;

    // FIFO write data: a returning sample, a header or the trailer (never two at once)
    always_comb begin
        push      = inflight | hdr_push | trl_push;
        push_word = {1'b0, sample};
        if (hdr_push)
            push_word = {1'b0, 4'hA, 4'(ch_q), (WIDTH-8)'(hm_q)};
        else if (trl_push)
            push_word = {1'b1, 4'hE, 3'b000, timeout_err, {(WIDTH-8){1'b0}}};
    end

    // FSM state register
    always_ff @(posedge CK50 or negedge RST_n) begin
        if (!RST_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Event context, per-channel counters, timeout timer and status flags
    always_ff @(posedge CK50 or negedge RST_n) begin
        if (!RST_n) begin
            ch_q        <= '0;
            mask_q      <= '0;
            hm_q        <= '0;
            req_cnt     <= '0;
            rcv_cnt     <= '0;
            tmr         <= '0;
            trl_sent    <= 1'b0;
            inflight    <= 1'b0;
            timeout_err <= 1'b0;
            trig_lost   <= 1'b0;
        end else begin
            inflight  <= rd_req_en;
            trig_lost <= TRIGGER & (state_q != IDLE);
            if (accept) begin
                mask_q      <= ch_mask;
                hm_q        <= howmany;
                ch_q        <= first_ch;
                timeout_err <= 1'b0;
                trl_sent    <= 1'b0;
            end else if (state_q == NEXT && nxt_found) begin
                ch_q <= nxt_ch;
            end
            if (hdr_push) begin
                req_cnt <= '0;
                rcv_cnt <= '0;
            end else begin
                if (rd_req_en) req_cnt <= req_cnt + 1'b1;
                if (inflight)  rcv_cnt <= rcv_cnt + 1'b1;
            end
            tmr <= (state_q == WAITDN) ? tmr + 1'b1 : '0;
            if (tmo)      timeout_err <= 1'b1;
            if (trl_push) trl_sent    <= 1'b1;
        end
    end

    // Output FIFO storage and occupancy
    always_ff @(posedge CK50 or negedge RST_n) begin
        if (!RST_n) begin
            mem      <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_digi_readout_sched.sv
// Directed bench for digi_readout_sched: framing, backpressure, zero-length,
// timeout, lost trigger and mid-event reset.
module tb_digi_readout_sched;

    logic        CK50 = 1'b0;
    logic        RST_n = 1'b0;
    logic        TRIGGER = 1'b0;
    logic [3:0]  ch_mask = '0;
    logic [7:0]  howmany = '0;
    logic [3:0]  ch_rodone_n = '0;
    logic [63:0] ch_dout;
    logic [3:0]  ch_rd_request;
    logic [15:0] ro_data;
    logic        ro_valid;
    logic        ro_ready = 1'b0;
    logic        ro_last;
    logic        busy;
    logic        trig_lost;
    logic        timeout_err;

    digi_readout_sched #(.NCH(4), .WIDTH(16), .SIZE(8), .TIMEOUT(255)) dut (
        .CK50(CK50), .RST_n(RST_n), .TRIGGER(TRIGGER), .ch_mask(ch_mask),
        .howmany(howmany), .ch_rodone_n(ch_rodone_n), .ch_dout(ch_dout),
        .ch_rd_request(ch_rd_request), .ro_data(ro_data), .ro_valid(ro_valid),
        .ro_ready(ro_ready), .ro_last(ro_last), .busy(busy),
        .trig_lost(trig_lost), .timeout_err(timeout_err)
    );

    always #10 CK50 = ~CK50;

    int total = 0, bad = 0;
    int viol = 0, stab_viol = 0, strobes = 0;
    int rdy_mode = 0, rc = 0;
    logic [16:0] cap[$];
    logic [16:0] exp_q[$];
    logic        pv = 1'b0, pr = 1'b0;
    logic [16:0] pd = '0;
    logic [7:0]  seq [4];

    // Channel slice model: word {5, ch, seq} appears one cycle after the strobe
    always @(posedge CK50 or negedge RST_n) begin
        if (!RST_n) begin
            ch_dout <= '0;
            for (int k = 0; k < 4; k++) seq[k] <= '0;
        end else begin
            for (int k = 0; k < 4; k++)
                if (ch_rd_request[k]) begin
                    ch_dout[k*16 +: 16] <= {4'h5, 4'(k), seq[k]};
                    seq[k] <= seq[k] + 8'd1;
                end
        end
    end

    // Downstream ready: always high, or high one cycle in three
    always begin
        @(posedge CK50);
        #1;
        rc++;
        ro_ready = (rdy_mode == 0) || (rc % 3 == 0);
    end

    // Monitor: capture transfers, strobe sanity, output stability under stall
    always @(negedge CK50) begin
        if ($countones(ch_rd_request) > 1) viol++;
        if ((ch_rd_request != 4'b0) && !busy) viol++;
        strobes += $countones(ch_rd_request);
        if (RST_n && pv && !pr && ({ro_last, ro_data} != pd)) stab_viol++;
        pv = ro_valid;
        pr = ro_ready;
        pd = {ro_last, ro_data};
        if (RST_n && ro_valid && ro_ready) cap.push_back({ro_last, ro_data});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CK50);
            #1;
        end
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        TRIGGER = 1'b0;
        cyc(2);
        RST_n = 1'b1;
        cyc(1);
        cap.delete();
    endtask

    task automatic trig(input logic [3:0] m, input logic [7:0] hm);
        @(posedge CK50);
        #1;
        TRIGGER = 1'b1;
        ch_mask = m;
        howmany = hm;
        @(posedge CK50);
        #1;
        TRIGGER = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            cyc(1);
            n++;
        end
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
        cyc(2);
    endtask

    // Expected frame: header + samples per enabled channel, then trailer
    task automatic build_exp(input logic [3:0] m, input logic [7:0] hm, input logic tbit);
        exp_q.delete();
        for (int k = 0; k < 4; k++)
            if (m[k]) begin
                exp_q.push_back({1'b0, 4'hA, 4'(k), hm});
                for (int j = 0; j < int'(hm); j++)
                    exp_q.push_back({1'b0, 4'h5, 4'(k), 8'(j)});
            end
        exp_q.push_back({1'b1, 4'hE, 3'b000, tbit, 8'h00});
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_len"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), {15'b0, cap[i]}, {15'b0, exp_q[i]});
    endtask

    initial begin
        int s0;
        // reset state
        RST_n = 1'b0;
        #5;
        chk("rst_outs", {17'b0, ro_valid, ro_last, busy, trig_lost, timeout_err, ch_rd_request, ro_data}, 32'd0);
        do_reset();

        // 1: two channels, free-running downstream
        rdy_mode = 0;
        trig(4'b0101, 8'd3);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        wait_idle("t1");
        build_exp(4'b0101, 8'd3, 1'b0);
        check_stream("t1");
        chk("t1_terr", {31'b0, timeout_err}, 32'd0);

        // 2: same event, ready one cycle in three
        do_reset();
        rdy_mode = 1;
        trig(4'b0101, 8'd3);
        wait_idle("t2");
        check_stream("t2");
        rdy_mode = 0;

        // 3: zero-length read on channel 3
        do_reset();
        s0 = strobes;
        trig(4'b1000, 8'd0);
        wait_idle("t3");
        build_exp(4'b1000, 8'd0, 1'b0);
        check_stream("t3");
        chk("t3_nostrobe", strobes - s0, 32'd0);

        // 4: channel 1 never reports done
        do_reset();
        ch_rodone_n = 4'b0010;
        trig(4'b0010, 8'd2);
        wait_idle("t4");
        build_exp(4'b0010, 8'd2, 1'b1);
        check_stream("t4");
        chk("t4_terr", {31'b0, timeout_err}, 32'd1);
        cyc(5);
        chk("t4_terr_hold", {31'b0, timeout_err}, 32'd1);
        ch_rodone_n = 4'b0000;
        cap.delete();
        trig(4'b0001, 8'd1);
        chk("t4_terr_clr", {31'b0, timeout_err}, 32'd0);
        wait_idle("t4b");
        build_exp(4'b0001, 8'd1, 1'b0);
        check_stream("t4b");

        // 5: trigger during an event, then trigger with empty mask
        do_reset();
        trig(4'b0101, 8'd3);
        cyc(4);
        TRIGGER = 1'b1;
        ch_mask = 4'b1111;
        howmany = 8'd5;
        @(posedge CK50);
        #1;
        TRIGGER = 1'b0;
        chk("t5_lost", {31'b0, trig_lost}, 32'd1);
        cyc(1);
        chk("t5_lost_pulse", {31'b0, trig_lost}, 32'd0);
        wait_idle("t5");
        build_exp(4'b0101, 8'd3, 1'b0);
        check_stream("t5");
        cap.delete();
        trig(4'b0000, 8'd3);
        chk("t5_mask0_busy", {30'b0, busy, trig_lost}, 32'd0);
        cyc(5);
        chk("t5_mask0_out", cap.size(), 32'd0);

        // 6: asynchronous reset while reading
        do_reset();
        trig(4'b0101, 8'd3);
        cyc(3);
        #3;
        RST_n = 1'b0;
        #1;
        chk("t6_async", {17'b0, ro_valid, ro_last, busy, trig_lost, timeout_err, ch_rd_request, ro_data}, 32'd0);
        cyc(2);
        RST_n = 1'b1;
        cyc(1);
        cap.delete();
        trig(4'b0101, 8'd3);
        wait_idle("t6");
        build_exp(4'b0101, 8'd3, 1'b0);
        check_stream("t6");

        chk("strobe_rules", viol, 32'd0);
        chk("stall_stable", stab_viol, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
